// File: rtl/iob_sync_fifo_if.sv
// ----------------------------------------------------------------------------
// iob_sync_fifo_if
// Groups the handshake and status signals of iob_sync_fifo into one bundle.
//   master modport : the FIFO user (drives w_en/data_in/r_en, observes status)
//   slave  modport : the FIFO itself (receives requests, drives data/status)
// Signals:
//   w_en, data_in        write request and write data
//   r_en, data_out       read request and registered read data
//   full, empty          level == depth / level == 0
//   almost_full/_empty   level >= AF_LEVEL / level <= AE_LEVEL
//   level                number of stored words (ADDR_W+1 bits)
//   overflow/underflow   one-cycle pulses for rejected write/read
// ----------------------------------------------------------------------------
interface iob_sync_fifo_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
);
   logic              w_en;
   logic [DATA_W-1:0] data_in;
   logic              r_en;
   logic [DATA_W-1:0] data_out;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic [ADDR_W:0]   level;
   logic              overflow;
   logic              underflow;

   modport master (
      output w_en, data_in, r_en,
      input  data_out, full, empty, almost_full, almost_empty, level, overflow, underflow
   );

   modport slave (
      input  w_en, data_in, r_en,
      output data_out, full, empty, almost_full, almost_empty, level, overflow, underflow
   );
endinterface

// File: rtl/iob_sync_fifo.sv
// ----------------------------------------------------------------------------
// iob_sync_fifo
// Single-clock FIFO with registered read data and registered status flags.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset (clears pointers, level, flags,
//         data_out; storage itself is not cleared)
//   fifo  iob_sync_fifo_if.slave bundle (requests in, data/status out)
// Parameters:
//   DATA_W   word width
//   ADDR_W   log2 of depth
//   USE_RAM  1: storage written as a block-RAM style array with a synchronous
//            read port; 0: register array with a mux into a data register.
//            Both give the same cycle behaviour at the ports.
//   AF_LEVEL almost_full threshold (level >= AF_LEVEL)
//   AE_LEVEL almost_empty threshold (level <= AE_LEVEL)
// ----------------------------------------------------------------------------
module iob_sync_fifo #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 4,
   parameter int USE_RAM  = 1,
   parameter int AF_LEVEL = 2**ADDR_W - 2,
   parameter int AE_LEVEL = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   iob_sync_fifo_if.slave       fifo
);

   localparam int                DEPTH   = 2**ADDR_W;
   localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   AF_L    = (ADDR_W+1)'(AF_LEVEL);
   localparam logic [ADDR_W:0]   AE_L    = (ADDR_W+1)'(AE_LEVEL);
   localparam logic [ADDR_W:0]   LVL_ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

   logic [ADDR_W-1:0] w_ptr_q, w_ptr_d;
   logic [ADDR_W-1:0] r_ptr_q, r_ptr_d;
   logic [ADDR_W:0]   level_q, level_d;
   logic              full_q, full_d;
   logic              empty_q, empty_d;
   logic              almost_full_q, almost_full_d;
   logic              almost_empty_q, almost_empty_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;
   logic              wr_acc_s;
   logic              rd_acc_s;
   logic [DATA_W-1:0] rd_data_s;

   // Acceptance: requests are judged against the registered flags only, so a
   // same-cycle read never frees room for a write and vice versa.
   always_comb begin
      wr_acc_s    = fifo.w_en & ~full_q;
      rd_acc_s    = fifo.r_en & ~empty_q;
      overflow_d  = fifo.w_en & full_q;
      underflow_d = fifo.r_en & empty_q;
   end

   // Pointer advance on accepted transfers; natural ADDR_W-bit wrap.
   always_comb begin
      if (wr_acc_s) begin
         w_ptr_d = w_ptr_q + PTR_ONE;
      end else begin
         w_ptr_d = w_ptr_q;
      end
      if (rd_acc_s) begin
         r_ptr_d = r_ptr_q + PTR_ONE;
      end else begin
         r_ptr_d = r_ptr_q;
      end
   end

   // Next level and the flags derived from it, so flags match level each cycle.
   always_comb begin
      case ({wr_acc_s, rd_acc_s})
         2'b10:   level_d = level_q + LVL_ONE;
         2'b01:   level_d = level_q - LVL_ONE;
         default: level_d = level_q;
      endcase
      full_d         = (level_d == DEPTH_L);
      empty_d        = (level_d == {(ADDR_W+1){1'b0}});
      almost_full_d  = (level_d >= AF_L);
      almost_empty_d = (level_d <= AE_L);
   end

   // Control state registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_ptr_q        <= {ADDR_W{1'b0}};
         r_ptr_q        <= {ADDR_W{1'b0}};
         level_q        <= {(ADDR_W+1){1'b0}};
         full_q         <= 1'b0;
         empty_q        <= 1'b1;
         almost_full_q  <= 1'b0;
         almost_empty_q <= 1'b1;
         overflow_q     <= 1'b0;
         underflow_q    <= 1'b0;
      end else begin
         w_ptr_q        <= w_ptr_d;
         r_ptr_q        <= r_ptr_d;
         level_q        <= level_d;
         full_q         <= full_d;
         empty_q        <= empty_d;
         almost_full_q  <= almost_full_d;
         almost_empty_q <= almost_empty_d;
         overflow_q     <= overflow_d;
         underflow_q    <= underflow_d;
      end
   end

   if (USE_RAM != 0) begin : g_ram
      logic [DATA_W-1:0] mem [DEPTH];
      logic [DATA_W-1:0] ram_dout_q;
      logic              dout_vld_q, dout_vld_d;

      // RAM port: write plus read-first synchronous read; no reset on the array.
      always_ff @(posedge clk) begin
         if (wr_acc_s) begin
            mem[w_ptr_q] <= fifo.data_in;
         end
         if (rd_acc_s) begin
            ram_dout_q <= mem[r_ptr_q];
         end
      end

      // The RAM output latch cannot be reset, so a valid flag forces zero
      // until the first read after reset.
      always_comb begin
         dout_vld_d = dout_vld_q | rd_acc_s;
      end

      // Valid flag register.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            dout_vld_q <= 1'b0;
         end else begin
            dout_vld_q <= dout_vld_d;
         end
      end

      assign rd_data_s = dout_vld_q ? ram_dout_q : {DATA_W{1'b0}};
   end else begin : g_reg
      logic [DATA_W-1:0] mem_q [DEPTH];
      logic [DATA_W-1:0] data_out_q, data_out_d;

      // Register-array storage write; contents are not reset.
      always_ff @(posedge clk) begin
         if (wr_acc_s) begin
            mem_q[w_ptr_q] <= fifo.data_in;
         end
      end

      // Read mux into the output register; hold when no read is accepted.
      always_comb begin
         if (rd_acc_s) begin
            data_out_d = mem_q[r_ptr_q];
         end else begin
            data_out_d = data_out_q;
         end
      end

      // Output data register.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            data_out_q <= {DATA_W{1'b0}};
         end else begin
            data_out_q <= data_out_d;
         end
      end

      assign rd_data_s = data_out_q;
   end

   assign fifo.data_out     = rd_data_s;
   assign fifo.full         = full_q;
   assign fifo.empty        = empty_q;
   assign fifo.almost_full  = almost_full_q;
   assign fifo.almost_empty = almost_empty_q;
   assign fifo.level        = level_q;
   assign fifo.overflow     = overflow_q;
   assign fifo.underflow    = underflow_q;

endmodule

// File: doc/iob_sync_fifo.md
IOB_SYNC_FIFO -- requirements
Module: iob_sync_fifo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning log2 of depth; depth = 2**ADDR_W.
REQ-003 The block SHALL have parameter USE_RAM, default 1, meaning 1 = storage inferred as block RAM, 0 = storage in registers; the two settings SHALL be cycle-identical at the ports.
REQ-004 The block SHALL have parameter AF_LEVEL, default 2**ADDR_W-2, meaning the almost_full threshold.
REQ-005 The block SHALL have parameter AE_LEVEL, default 2, meaning the almost_empty threshold.
REQ-006 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-007 clk  input  1  clock; all state updates on the rising edge.
REQ-008 rst  input  1  asynchronous active-high reset.
REQ-009 w_en  input  1  write request.
REQ-010 data_in  input  DATA_W  write data.
REQ-011 r_en  input  1  read request.
REQ-012 data_out  output  DATA_W  read data, registered.
REQ-013 full  output  1  level == 2**ADDR_W.
REQ-014 empty  output  1  level == 0.
REQ-015 almost_full  output  1  level >= AF_LEVEL.
REQ-016 almost_empty  output  1  level <= AE_LEVEL.
REQ-017 level  output  ADDR_W+1  number of stored words, 0..2**ADDR_W.
REQ-018 overflow  output  1  one-cycle pulse, write rejected.
REQ-019 underflow  output  1  one-cycle pulse, read rejected.

Function
REQ-020 A write SHALL be accepted when w_en=1 and full=0; data_in is stored at the write pointer, and the write pointer increments.
REQ-021 A read SHALL be accepted when r_en=1 and empty=0; the word at the read pointer is registered into data_out on that same edge, and the read pointer increments.
REQ-022 Read latency SHALL be one cycle: data_out is valid after the edge that accepts the read.
REQ-023 data_out SHALL hold its value until the next accepted read.
REQ-024 The write and read pointers SHALL be ADDR_W bits wide and wrap from 2**ADDR_W-1 to 0 with no gap.
REQ-025 On each edge, level SHALL be updated as follows: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-026 full, empty, almost_full and almost_empty SHALL be registered and consistent with level in the same cycle.
REQ-027 When full=1, w_en=1 SHALL be rejected even if a read is accepted in the same cycle; storage and write pointer SHALL be unchanged and overflow SHALL pulse high for one cycle.
REQ-028 When empty=1, r_en=1 SHALL be rejected even if a write is accepted in the same cycle; there is no bypass, data_out SHALL be unchanged and underflow SHALL pulse high for one cycle.
REQ-029 A simultaneous accepted read and write SHALL preserve FIFO order; a read at the address being written SHALL return the previously stored word.
REQ-030 Words SHALL be delivered strictly in write order across pointer wrap-around.

Reset
REQ-031 While rst=1, asynchronously: pointers SHALL be 0, level=0, empty=1, full=0, almost_full=0, almost_empty=1, data_out=0, overflow=0, underflow=0.
REQ-032 Storage contents SHALL NOT be reset; after reset, no stale word SHALL be readable.
REQ-033 Reset asserted mid-operation SHALL discard all stored words within the same cycle.

Verification
REQ-034 Fill test (DATA_W=8, ADDR_W=4): write 32..47 on 16 consecutive cycles -> after the 16th edge level=16, full=1, almost_full=1 (from level 14), empty=0.
REQ-035 Overflow test: from full, w_en=1 with r_en=1 -> overflow=1 for one cycle, read accepted, level=15; the rejected word never appears at data_out.
REQ-036 Drain test: from full, r_en=1 for 16 cycles -> data_out=32..47 one cycle after each read, then empty=1, almost_empty=1 from level 2; a 17th read -> underflow=1, data_out stays 47.
REQ-037 Wrap test: interleave 40 writes (values 0..39) and reads keeping level between 3 and 6 -> reads return 0..39 in order; level stays unchanged on cycles with both read and write.
REQ-038 Reset test: at level 7, assert rst between clock edges -> immediately level=0, empty=1, data_out=0; a subsequent read -> underflow=1.
REQ-039 All scenarios SHALL pass with USE_RAM=0 and with USE_RAM=1, with identical cycle-by-cycle port traces.
